branch_selector: RTL and testbench

BRANCH_SELECTOR -- requirements
Module: branch_selector

---
 rtl/branch_selector_pkg.sv | 26 ++
 rtl/branch_selector_if.sv | 18 +
 rtl/btu_fifo.sv | 70 +++++++
 rtl/branch_selector.sv | 73 +++++++
 tb/tb_branch_selector.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/branch_selector_pkg.sv
// Shared branch types and the wrap-safe sequence-number ordering helper.
package branch_selector_pkg;
  localparam int SQN_W = 7;

  typedef logic [SQN_W-1:0] SqN;

  typedef struct packed {
    logic        taken;
    SqN          sqN;
    logic [31:0] dstPC;
  } BranchProv;

  typedef struct packed {
    logic        valid;
    logic [31:0] src;
    logic [31:0] dst;
    logic        isJump;
  } BTUpdate;

  // a is older than b when the modular distance a-b is negative
  function automatic logic sqn_older(SqN a, SqN b);
    SqN d;
    d = a - b;
    return d[SQN_W-1];
  endfunction
endpackage

// File: rtl/branch_selector_if.sv
// Port bundle between the branch ports / BTB and the branch selector.
interface branch_selector_if
  import branch_selector_pkg::*;
#(
  parameter int NUM_PORTS = 4
);
  BranchProv   IN_branches  [NUM_PORTS];
  BTUpdate     IN_btUpdates [NUM_PORTS];
  logic        IN_btReady;
  BranchProv   OUT_branch;
  BTUpdate     OUT_btUpdate;
  logic [15:0] OUT_btDropCnt;

  modport master (output IN_branches, IN_btUpdates, IN_btReady,
                  input  OUT_branch, OUT_btUpdate, OUT_btDropCnt);
  modport slave  (input  IN_branches, IN_btUpdates, IN_btReady,
                  output OUT_branch, OUT_btUpdate, OUT_btDropCnt);
endinterface

// File: rtl/btu_fifo.sv
// Multi-push circular FIFO; pushes fill slots freed by this cycle's pop, excess is reported as drops.
module btu_fifo #(
  parameter int  DEPTH  = 4,
  parameter int  NUM_IN = 4,
  parameter type T      = logic,
  localparam int DW     = $clog2(NUM_IN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] push_vld_i,
  input  T                  push_data_i [NUM_IN],
  input  logic              pop_i,
  output T                  head_o,
  output logic              empty_o,
  output logic [DW-1:0]     drops_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = AW + 2;

  T                            mem_q [DEPTH];
  logic [PW-1:0]               wptr_q, wptr_d, rptr_q, rptr_d, cnt;
  logic                        pop;
  logic [CW-1:0]               free, acc;
  logic [DW-1:0]               drop;
  logic [NUM_IN-1:0]           wr_en;
  logic [NUM_IN-1:0][AW-1:0]   wr_idx;

  assign empty_o = (wptr_q == rptr_q);
  assign pop     = pop_i && !empty_o;
  assign cnt     = wptr_q - rptr_q;
  assign free    = CW'(DEPTH) - CW'(cnt) + CW'(pop);
  assign head_o  = mem_q[rptr_q[AW-1:0]];
  assign drops_o = drop;

  always_comb begin
    acc    = '0;
    drop   = '0;
    wr_en  = '0;
    wr_idx = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (push_vld_i[i]) begin
        if (acc < free) begin
          wr_en[i]  = 1'b1;
          wr_idx[i] = wptr_q[AW-1:0] + acc[AW-1:0];
          acc       = acc + CW'(1);
        end else begin
          drop = drop + DW'(1);
        end
      end
    end
    wptr_d = wptr_q + acc[PW-1:0];
    rptr_d = rptr_q + PW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_IN; i++)
      if (!rst && wr_en[i]) mem_q[wr_idx[i]] <= push_data_i[i];
  end
endmodule

// File: rtl/branch_selector.sv
// Picks the oldest qualifying redirect across branch ports and queues BTB training updates.
module branch_selector
  import branch_selector_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int BTU_DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  branch_selector_if.slave  bus
);
  localparam int DW = $clog2(NUM_PORTS + 1);

  BranchProv         branch_q, branch_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic [16:0]       drop_sum;
  logic [NUM_PORTS-1:0] push_vld;
  BTUpdate           push_data [NUM_PORTS];
  BTUpdate           head;
  logic              empty;
  logic [DW-1:0]     drops;

  // branch_d.taken doubles as "a winner has been found so far"
  always_comb begin
    branch_d       = branch_q;
    branch_d.taken = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (bus.IN_branches[i].taken &&
          (!branch_q.taken || sqn_older(bus.IN_branches[i].sqN, branch_q.sqN)) &&
          (!branch_d.taken || sqn_older(bus.IN_branches[i].sqN, branch_d.sqN)))
        branch_d = bus.IN_branches[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      push_vld[i]  = bus.IN_btUpdates[i].valid;
      push_data[i] = bus.IN_btUpdates[i];
    end
  end

  btu_fifo #(.DEPTH(BTU_DEPTH), .NUM_IN(NUM_PORTS), .T(BTUpdate)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_vld_i  (push_vld),
    .push_data_i (push_data),
    .pop_i       (bus.IN_btReady),
    .head_o      (head),
    .empty_o     (empty),
    .drops_o     (drops)
  );

  assign drop_sum   = {1'b0, drop_cnt_q} + 17'(drops);
  assign drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      branch_q   <= branch_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_comb begin
    bus.OUT_btUpdate       = head;
    bus.OUT_btUpdate.valid = !empty;
  end

  assign bus.OUT_branch    = branch_q;
  assign bus.OUT_btDropCnt = drop_cnt_q;
endmodule

// File: tb/tb_branch_selector.sv
// Randomized + directed bench for branch_selector against a queue-based reference model.
module tb_branch_selector;
  import branch_selector_pkg::*;

  localparam int NP    = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;

  branch_selector_if #(.NUM_PORTS(NP)) bus ();

  branch_selector #(.NUM_PORTS(NP), .BTU_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // reference state
  logic        m_taken = 1'b0;
  SqN          m_sqn   = '0;
  logic [31:0] m_pc    = '0;
  BTUpdate     m_q[$];
  int          m_drop  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // sequence numbers live on a 128-entry ring; a is older if b is within the forward half from a
  function automatic bit older(input int a, input int b);
    return ((a - b) & 127) >= 64;
  endfunction

  task automatic idle();
    for (int i = 0; i < NP; i++) begin
      bus.IN_branches[i]  = '0;
      bus.IN_btUpdates[i] = '0;
    end
    bus.IN_btReady = 1'b0;
  endtask

  task automatic set_br(input int p, input SqN s, input logic [31:0] pc);
    bus.IN_branches[p].taken = 1'b1;
    bus.IN_branches[p].sqN   = s;
    bus.IN_branches[p].dstPC = pc;
  endtask

  task automatic set_upd(input int p, input logic [31:0] src);
    bus.IN_btUpdates[p].valid  = 1'b1;
    bus.IN_btUpdates[p].src    = src;
    bus.IN_btUpdates[p].dst    = ~src;
    bus.IN_btUpdates[p].isJump = src[0];
  endtask

  task automatic model_tick();
    int best;
    best = -1;
    if (rst) begin
      m_taken = 1'b0;
      m_q.delete();
      m_drop = 0;
      return;
    end
    for (int i = 0; i < NP; i++) begin
      if (bus.IN_branches[i].taken && (!m_taken || older(int'(bus.IN_branches[i].sqN), int'(m_sqn))))
        if (best < 0 || older(int'(bus.IN_branches[i].sqN), int'(bus.IN_branches[best].sqN)))
          best = i;
    end
    if (best >= 0) begin
      m_taken = 1'b1;
      m_sqn   = bus.IN_branches[best].sqN;
      m_pc    = bus.IN_branches[best].dstPC;
    end else begin
      m_taken = 1'b0;
    end
    if (m_q.size() > 0 && bus.IN_btReady) void'(m_q.pop_front());
    for (int i = 0; i < NP; i++) begin
      if (bus.IN_btUpdates[i].valid) begin
        if (m_q.size() < DEPTH) m_q.push_back(bus.IN_btUpdates[i]);
        else if (m_drop < 65535) m_drop++;
      end
    end
  endtask

  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
    chk("br_taken", 64'(bus.OUT_branch.taken), 64'(m_taken));
    if (m_taken) begin
      chk("br_sqn", 64'(bus.OUT_branch.sqN), 64'(m_sqn));
      chk("br_pc", 64'(bus.OUT_branch.dstPC), 64'(m_pc));
    end
    chk("btu_valid", 64'(bus.OUT_btUpdate.valid), 64'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("btu_src", 64'(bus.OUT_btUpdate.src), 64'(m_q[0].src));
      chk("btu_dst", 64'(bus.OUT_btUpdate.dst), 64'(m_q[0].dst));
      chk("btu_jmp", 64'(bus.OUT_btUpdate.isJump), 64'(m_q[0].isJump));
    end
    chk("drop_cnt", 64'(bus.OUT_btDropCnt), 64'(m_drop));
  endtask

  logic [31:0] exp_seq [8];

  initial begin
    idle();
    rst = 1'b1;
    step();
    step();
    chk("rst_taken", 64'(bus.OUT_branch.taken), 64'd0);
    chk("rst_valid", 64'(bus.OUT_btUpdate.valid), 64'd0);
    chk("rst_drop", 64'(bus.OUT_btDropCnt), 64'd0);
    rst = 1'b0;

    // oldest of two simultaneous requests
    set_br(1, 7'h12, 32'h1111);
    set_br(3, 7'h0F, 32'h3333);
    step();
    chk("r028_sqn", 64'(bus.OUT_branch.sqN), 64'h0F);
    chk("r028_pc", 64'(bus.OUT_branch.dstPC), 64'h3333);
    idle();
    step();

    // ordering across the sqN wrap
    set_br(0, 7'h7E, 32'h7E7E);
    step();
    chk("r029_base", 64'(bus.OUT_branch.sqN), 64'h7E);
    idle();
    set_br(0, 7'h01, 32'h0101);
    set_br(2, 7'h7D, 32'h7D7D);
    step();
    chk("r029_sel", 64'(bus.OUT_branch.dstPC), 64'h7D7D);
    idle();
    set_br(0, 7'h01, 32'h0101);
    step();
    chk("r029_young", 64'(bus.OUT_branch.taken), 64'd0);

    // equal sqN tie-break and no duplicate redirect
    idle();
    step();
    set_br(0, 7'h20, 32'h00A0);
    set_br(2, 7'h20, 32'h00A2);
    step();
    chk("r030_tie", 64'(bus.OUT_branch.dstPC), 64'h00A0);
    step();
    chk("r030_dup", 64'(bus.OUT_branch.taken), 64'd0);

    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;

    // fill to full with the BTB stalled, then overflow twice
    for (int k = 0; k < 6; k++) begin
      idle();
      set_upd(0, 32'hA000_0000 + k);
      step();
    end
    idle();
    chk("r031_drop", 64'(bus.OUT_btDropCnt), 64'd2);
    chk("r031_head", 64'(bus.OUT_btUpdate.src), 64'hA000_0000);

    // pop+push on full, across the pointer wrap
    for (int k = 0; k < 4; k++) begin
      exp_seq[k]     = 32'hA000_0000 + k;
      exp_seq[4 + k] = 32'hB000_0000 + k;
    end
    for (int k = 0; k < 4; k++) begin
      chk("r032_seq", 64'(bus.OUT_btUpdate.src), 64'(exp_seq[k]));
      idle();
      bus.IN_btReady = 1'b1;
      set_upd(1, 32'hB000_0000 + k);
      step();
      chk("r032_nodrop", 64'(bus.OUT_btDropCnt), 64'd2);
    end
    idle();
    bus.IN_btReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("r032_seq", 64'(bus.OUT_btUpdate.src), 64'(exp_seq[4 + k]));
      step();
    end
    chk("r032_empty", 64'(bus.OUT_btUpdate.valid), 64'd0);

    // reset with queued entries and a pending selection
    idle();
    for (int k = 0; k < 3; k++) set_upd(k, 32'hC000_0000 + k);
    step();
    idle();
    set_br(1, 7'h30, 32'h3030);
    set_upd(0, 32'hD000_0000);
    rst = 1'b1;
    step();
    chk("r033_valid", 64'(bus.OUT_btUpdate.valid), 64'd0);
    chk("r033_taken", 64'(bus.OUT_branch.taken), 64'd0);
    chk("r033_drop", 64'(bus.OUT_btDropCnt), 64'd0);
    rst = 1'b0;
    idle();
    step();
    chk("r033_ignored", 64'(bus.OUT_btUpdate.valid), 64'd0);

    // randomized traffic, sqNs clustered around the current redirect
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NP; i++) begin
        bus.IN_branches[i].taken  = ($urandom % 4) == 0;
        bus.IN_branches[i].sqN    = SqN'(int'(m_sqn) + int'($urandom_range(0, 15)) - 8);
        bus.IN_branches[i].dstPC  = $urandom;
        bus.IN_btUpdates[i].valid = ($urandom % 3) == 0;
        bus.IN_btUpdates[i].src   = $urandom;
        bus.IN_btUpdates[i].dst   = $urandom;
        bus.IN_btUpdates[i].isJump = ($urandom % 2) == 1;
      end
      bus.IN_btReady = ($urandom % 2) == 1;
      rst = ($urandom % 300) == 0;
      step();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
